// File: rtl/seq_vector_checker.sv
// Purpose: buffers up to DEPTH test vectors {x,y,zexp}, replays them to an external circuit and counts z mismatches.
// Latency: vector k appears on x/y k+1 cycles after start; its response is compared LAT cycles later; done pulses after LAT drain cycles.
// Backpressure: none; writes beyond DEPTH, or made outside IDLE, are dropped, and start outside IDLE is ignored.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   wr_en, wr_x/y/zexp, clr   vector buffer load and clear (accepted in IDLE only)
//   start                     begin replay of the buffered vectors
//   x, y / z                  registered stimulus to, and response from, the circuit under test
//   full, busy, done          buffer full, replay in progress, one-cycle end-of-replay pulse
//   pass, err_cnt, first_err_idx  results of the most recent replay
module seq_vector_checker #(
    parameter int DEPTH = 8,
    parameter int LAT   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic                       wr_x,
    input  logic                       wr_y,
    input  logic                       wr_zexp,
    input  logic                       clr,
    input  logic                       start,
    output logic                       x,
    output logic                       y,
    input  logic                       z,
    output logic                       full,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [$clog2(DEPTH+1)-1:0] err_cnt,
    output logic [$clog2(DEPTH)-1:0]   first_err_idx
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state, state_nxt;
    logic [2:0]      mem [DEPTH];
    logic [CW-1:0]   count;
    logic [CW-1:0]   rd_idx;      // index of the next vector to put on x/y
    logic [IW-1:0]   cmp_idx;     // index of the vector whose response is compared this cycle
    logic [2:0]      drain_cnt;
    logic            cur_zexp;    // expected z of the vector currently on x/y
    logic [LAT-1:0]  sr_zexp;     // expected z delayed to line up with the response
    logic [LAT-1:0]  sr_vld;
    logic            mism;
    logic [CW-1:0]   err_cnt_nxt;
    logic            wr_ok;

    assign full  = (count == CW'(DEPTH));
    assign busy  = (state == RUN) || (state == DRAIN);
    assign done  = (state == DONE);
    assign wr_ok = (state == IDLE) && wr_en && !start && !clr && !full;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (count == '0) ? DONE : RUN;
            RUN:     if (rd_idx == count) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == 3'(LAT - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mism        = sr_vld[LAT-1] && (z != sr_zexp[LAT-1]);
        err_cnt_nxt = err_cnt;
        if (mism && (err_cnt != '1)) err_cnt_nxt = err_cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Buffer storage carries no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[count[IW-1:0]] <= {wr_x, wr_y, wr_zexp};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count         <= '0;
            rd_idx        <= '0;
            cmp_idx       <= '0;
            drain_cnt     <= '0;
            x             <= 1'b0;
            y             <= 1'b0;
            cur_zexp      <= 1'b0;
            sr_zexp       <= '0;
            sr_vld        <= '0;
            pass          <= 1'b0;
            err_cnt       <= '0;
            first_err_idx <= '0;
        end else begin
            // Only vectors driven during RUN enter the compare pipeline.
            sr_zexp[0] <= cur_zexp;
            sr_vld[0]  <= (state == RUN);
            for (int i = 1; i < LAT; i++) begin
                sr_zexp[i] <= sr_zexp[i-1];
                sr_vld[i]  <= sr_vld[i-1];
            end

            if (sr_vld[LAT-1]) cmp_idx <= cmp_idx + IW'(1);
            if (mism) begin
                err_cnt <= err_cnt_nxt;
                // err_cnt is cleared at start and never wraps, so zero marks the first miss.
                if (err_cnt == '0) first_err_idx <= cmp_idx;
            end

            case (state)
                IDLE: begin
                    x <= 1'b0;
                    y <= 1'b0;
                    if (start) begin
                        err_cnt       <= '0;
                        first_err_idx <= '0;
                        cmp_idx       <= '0;
                        if (count == '0) begin
                            pass <= 1'b1;
                        end else begin
                            {x, y, cur_zexp} <= mem[0];
                            rd_idx           <= CW'(1);
                        end
                    end else if (clr) begin
                        count <= '0;
                    end else if (wr_ok) begin
                        count <= count + CW'(1);
                    end
                end
                RUN: begin
                    if (rd_idx == count) begin
                        x         <= 1'b0;
                        y         <= 1'b0;
                        cur_zexp  <= 1'b0;
                        drain_cnt <= '0;
                    end else begin
                        {x, y, cur_zexp} <= mem[rd_idx[IW-1:0]];
                        rd_idx           <= rd_idx + CW'(1);
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 3'd1;
                    // The last compare lands on this same edge, so use the updated count.
                    if (state_nxt == DONE) pass <= (err_cnt_nxt == '0);
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: doc/seq_vector_checker.md
SEQ_VECTOR_CHECKER -- requirements
Module: seq_vector_checker

Interface
REQ-001 SHALL have parameter DEPTH, default 8, vector buffer entries (power of 2, 2..16).
REQ-002 SHALL have parameter LAT, default 1, cycles from x/y drive to z compare (1..4).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  append one vector to buffer.
REQ-006 SHALL have port wr_x, wr_y, wr_zexp  input  1 each  vector stimulus bits and expected z.
REQ-007 SHALL have port clr  input  1  empty the buffer.
REQ-008 SHALL have port start  input  1  begin replay of buffered vectors.
REQ-009 SHALL have port x, y  output  1 each  registered stimulus to the circuit under test.
REQ-010 SHALL have port z  input  1  response from the circuit under test.
REQ-011 SHALL have port full  output  1  buffer holds DEPTH vectors.
REQ-012 SHALL have port busy  output  1  replay in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse at replay end.
REQ-014 SHALL have port pass  output  1  last replay had zero mismatches.
REQ-015 SHALL have port err_cnt  output  clog2(DEPTH+1)  mismatch count of last replay.
REQ-016 SHALL have port first_err_idx  output  clog2(DEPTH)  index of first mismatching vector.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-018 In IDLE, wr_en with full=0 and start=0 SHALL store {wr_x,wr_y,wr_zexp} at index count and increment count; wr_en with full=1 SHALL be dropped.
REQ-019 wr_en and clr SHALL be ignored outside IDLE; clr in IDLE SHALL set count=0 and has priority over wr_en.
REQ-020 start in IDLE SHALL have priority over a same-cycle wr_en (write dropped); start outside IDLE SHALL be ignored.
REQ-021 start in IDLE with count=0 SHALL go to DONE next edge with err_cnt=0, pass=1.
REQ-022 start in IDLE with count>0 SHALL clear err_cnt, go to RUN, and drive vector 0 on x/y in the next cycle.
REQ-023 RUN SHALL drive vector k on x/y in cycle k (k=0..count-1), one vector per cycle, no gaps.
REQ-024 Response to vector k SHALL be compared at the edge ending cycle k+LAT (zexp delayed through a LAT-deep pipeline).
REQ-025 After the last vector, DRAIN SHALL hold x=y=0 for LAT cycles while outstanding compares complete, then enter DONE.
REQ-026 Each mismatch (z != zexp) SHALL increment err_cnt, saturating at all-ones; first mismatch of a replay SHALL latch its index in first_err_idx.
REQ-027 DONE SHALL last one cycle with done=1, update pass=(err_cnt==0), then return to IDLE.
REQ-028 busy SHALL be 1 exactly in RUN and DRAIN; x=y=0 whenever not in RUN.
REQ-029 Buffer contents and count SHALL be retained after DONE so a second start replays identically.
REQ-030 pass, err_cnt, first_err_idx SHALL hold from DONE until the next start.

Reset
REQ-031 rst SHALL force IDLE, count=0, x=0, y=0, busy=0, done=0, pass=0, err_cnt=0, first_err_idx=0, pipeline cleared.
REQ-032 rst asserted mid-RUN/DRAIN SHALL abort the replay with no done pulse and apply REQ-031 at that edge.

Verification
REQ-033 Load (x,y,zexp)=(0,0,0),(1,0,1),(1,1,0),(0,1,1),(1,0,1),(0,0,0), DUT model z=x^y delayed 1, LAT=1, start -> x/y sequence matches, busy 7 cycles, done pulse, pass=1, err_cnt=0.
REQ-034 Same load with vector 3 zexp=0 -> err_cnt=1, first_err_idx=3, pass=0.
REQ-035 Write 9 vectors -> full=1 after 8th, 9th dropped, replay drives exactly 8 vectors.
REQ-036 start with empty buffer -> done pulse next cycle, pass=1, x=y=0 throughout.
REQ-037 rst during vector 2 of replay -> next cycle busy=0, x=y=0, full=0, no done pulse; new load/replay then passes.
REQ-038 start twice without reload, start held high during RUN -> identical results, mid-run start ignored.
